// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode sequencer feeding the execution unit (EU).
// Fetches 19-bit words over a variable-latency handshake, issues EU fields
// with a one-cycle strobe, holds them for EXEC_CYCLES, then latches flags.
// HALT (4'hE) is always handled locally.
// Optional feature macro: INSTR_SEQ_BRANCH_EN. When it is defined, 4'hF is
// decoded as branch-if-zero. When it is not defined, 4'hF is an ordinary
// EU opcode.
module instr_sequencer #(
  parameter int PC_W        = 8,
  parameter int EXEC_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_rd,
  output logic [PC_W-1:0] imem_addr,
  input  logic [18:0]     imem_data,
  input  logic            imem_valid,
  output logic [3:0]      opcode,
  output logic [4:0]      addr1,
  output logic [4:0]      addr2,
  output logic [4:0]      addr3,
  output logic            eu_start,
  input  logic [3:0]      flag,
  output logic [3:0]      flag_q,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALTED
  } state_t;

  state_t state_q, state_d;

  logic            imem_rd_q, imem_rd_d;
  logic            eu_start_q, eu_start_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [18:0]      instr_q, instr_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [4:0]       addr1_q, addr1_d;
  logic [4:0]       addr2_q, addr2_d;
  logic [4:0]       addr3_q, addr3_d;
  logic [3:0]       eu_flag_q, eu_flag_d;
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;

  logic is_halt, is_brz, exec_last;

  assign is_halt   = (instr_q[18:15] == 4'hE);
`ifdef INSTR_SEQ_BRANCH_EN
  assign is_brz    = (instr_q[18:15] == 4'hF);
`else
  assign is_brz    = 1'b0;
`endif
  assign exec_last = (exec_cnt_q == EXEC_LAST);

  // State and registered control outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      imem_rd_q  <= 1'b0;
      eu_start_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      imem_rd_q  <= imem_rd_d;
      eu_start_q <= eu_start_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
    end
  end

  // Next-state logic; run is only honoured at instruction boundaries
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (imem_valid) state_d = S_DECODE;
      S_DECODE: begin
        if (is_halt)     state_d = S_HALTED;
        else if (is_brz) state_d = run ? S_FETCH : S_IDLE;
        else             state_d = S_EXEC;
      end
      S_EXEC:   if (exec_last) state_d = run ? S_FETCH : S_IDLE;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control outputs computed from the next state so they are registered
  always_comb begin
    imem_rd_d  = (state_d == S_FETCH);
    eu_start_d = (state_d == S_EXEC) && (state_q != S_EXEC);
    busy_d     = (state_d != S_IDLE) && (state_d != S_HALTED);
    halted_d   = (state_d == S_HALTED);
  end

  // Datapath: instruction latch, EU fields, execute counter, pc and flags
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    opcode_d   = opcode_q;
    addr1_d    = addr1_q;
    addr2_d    = addr2_q;
    addr3_d    = addr3_q;
    eu_flag_d  = eu_flag_q;
    exec_cnt_d = exec_cnt_q;
    case (state_q)
      S_FETCH: if (imem_valid) instr_d = imem_data;
      S_DECODE: begin
        if (is_halt) begin
          pc_d = pc_q;
        end else if (is_brz) begin
`ifdef INSTR_SEQ_BRANCH_EN
          // Target is {addr2[2:0], addr3}, fitted to the pc width
          pc_d = eu_flag_q[0] ? PC_W'(instr_q[7:0]) : pc_q + PC_W'(1);
`endif
        end else begin
          opcode_d   = instr_q[18:15];
          addr1_d    = instr_q[14:10];
          addr2_d    = instr_q[9:5];
          addr3_d    = instr_q[4:0];
          exec_cnt_d = '0;
        end
      end
      S_EXEC: begin
        if (exec_last) begin
          eu_flag_d = flag;
          pc_d      = pc_q + PC_W'(1);
        end else begin
          exec_cnt_d = exec_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      instr_q    <= '0;
      opcode_q   <= '0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      addr3_q    <= '0;
      eu_flag_q  <= '0;
      exec_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      opcode_q   <= opcode_d;
      addr1_q    <= addr1_d;
      addr2_q    <= addr2_d;
      addr3_q    <= addr3_d;
      eu_flag_q  <= eu_flag_d;
      exec_cnt_q <= exec_cnt_d;
    end
  end

  assign imem_rd   = imem_rd_q;
  assign imem_addr = pc_q;
  assign opcode    = opcode_q;
  assign addr1     = addr1_q;
  assign addr2     = addr2_q;
  assign addr3     = addr3_q;
  assign eu_start  = eu_start_q;
  assign flag_q    = eu_flag_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed programs push expected fetch
// addresses and issued EU words; a monitor pops and compares them as the DUT
// presents fetch handshakes and eu_start strobes.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_rd;
  logic [7:0]  imem_addr;
  logic [18:0] imem_data = '0;
  logic        imem_valid = 1'b0;
  logic [3:0]  opcode;
  logic [4:0]  addr1, addr2, addr3;
  logic        eu_start;
  logic [3:0]  flag;
  logic [3:0]  flag_q;
  logic [7:0]  pc;
  logic        busy, halted;

  instr_sequencer #(.PC_W(8), .EXEC_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_valid(imem_valid),
    .opcode(opcode), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .eu_start(eu_start), .flag(flag), .flag_q(flag_q),
    .pc(pc), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  localparam logic [18:0] HALT = 19'h70000;
  localparam logic [18:0] W1   = {4'h1, 5'd1, 5'd2, 5'd3};
  localparam logic [18:0] W2   = {4'h2, 5'd4, 5'd5, 5'd6};
  localparam logic [18:0] W3   = {4'h3, 5'd7, 5'd8, 5'd9};
  localparam logic [18:0] BRZ  = {4'hF, 5'd0, 5'd2, 5'd4};

  logic [18:0] mem [256];
  int          waits = 0;
  bit          spurious = 1'b0;
  logic [3:0]  flag_drv = 4'h0;
  int          mcnt = 0;
  logic        mon_prev = 1'b0;

  assign flag = flag_drv;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  fetch_exp[$];
  logic [18:0] issue_exp[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (halted === 1'b1) break;
    end
    check(name, halted, 1);
  endtask

  task automatic check_drained(input string name);
    check({name, "_fetch_drained"}, fetch_exp.size(), 0);
    check({name, "_issue_drained"}, issue_exp.size(), 0);
  endtask

  // Memory model: answers after 'waits' cycles; optional junk valid while idle
  initial begin
    forever begin
      @(negedge clk);
      if (imem_rd === 1'b1) begin
        if (mcnt >= waits) begin
          imem_valid = 1'b1;
          imem_data  = mem[imem_addr];
        end else begin
          imem_valid = 1'b0;
          mcnt++;
        end
      end else begin
        mcnt       = 0;
        imem_valid = spurious;
        imem_data  = spurious ? 19'h0ABCD : 19'h0;
      end
    end
  end

  // Monitor: fetch handshakes and issue strobes against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (imem_rd === 1'b1 && imem_valid === 1'b1) begin
        if (fetch_exp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL fetch_unexpected: got addr %0h expected no fetch", imem_addr);
        end else begin
          check("fetch_addr", imem_addr, fetch_exp.pop_front());
        end
      end
      if (eu_start === 1'b1) begin
        check("eu_start_width", mon_prev, 0);
        if (issue_exp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL issue_unexpected: got %0h expected no issue",
                   {opcode, addr1, addr2, addr3});
        end else begin
          check("issue_fields", {opcode, addr1, addr2, addr3}, issue_exp.pop_front());
        end
      end
      mon_prev = eu_start;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int     n_rd;
    int     bad_addr;
    logic [7:0] pc_exp;

    for (int i = 0; i < 256; i++) mem[i] = '0;

    // A: reset state, zero-wait ALU op timing, HALT
    mem[0] = W1; mem[1] = HALT;
    flag_drv = 4'b0101; run = 1'b1;
    fetch_exp.push_back(8'h00); fetch_exp.push_back(8'h01);
    issue_exp.push_back(W1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {imem_rd, imem_addr, opcode, addr1, addr2, addr3,
                            eu_start, flag_q, pc, busy, halted}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("a_rd_c0", imem_rd, 1);
    check("a_addr_c0", imem_addr, 0);
    check("a_start_c0", eu_start, 0);
    @(negedge clk);
    check("a_rd_c1", imem_rd, 0);
    check("a_start_c1", eu_start, 0);
    @(negedge clk);
    check("a_start_c2", eu_start, 1);
    check("a_busy_c2", busy, 1);
    @(negedge clk);
    check("a_start_c3", eu_start, 0);
    check("a_flagq_c3", flag_q, 0);
    @(negedge clk);
    check("a_rd_c4", imem_rd, 1);
    check("a_addr_c4", imem_addr, 1);
    check("a_pc_c4", pc, 1);
    check("a_flagq_c4", flag_q, 4'b0101);
    wait_halt("a_halt", 20);
    check("a_busy_halted", busy, 0);
    check("a_pc_halted", pc, 1);
    n_rd = 0;
    repeat (5) begin
      @(negedge clk);
      if (imem_rd === 1'b1) n_rd++;
    end
    check("a_no_rd_after_halt", n_rd, 0);
    check_drained("a");

    // B: 3 wait states, junk valid while not fetching, run dropped in EXEC
    mem[0] = W2; mem[1] = W3; mem[2] = HALT;
    waits = 3; spurious = 1'b1; flag_drv = 4'b1010; run = 1'b1;
    fetch_exp.push_back(8'h00);
    issue_exp.push_back(W2);
    do_reset();
    n_rd = 0; bad_addr = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (imem_rd === 1'b1) begin
        n_rd++;
        if (imem_addr !== 8'h00) bad_addr++;
      end else if (n_rd > 0) begin
        break;
      end
    end
    check("b_rd_cycles", n_rd, 4);
    check("b_addr_stable", bad_addr, 0);
    for (int i = 0; i < 10; i++) begin
      if (eu_start === 1'b1) break;
      @(negedge clk);
    end
    check("b_issue_seen", eu_start, 1);
    run = 1'b0;
    repeat (4) @(negedge clk);
    check("b_idle_pc", pc, 1);
    check("b_idle_busy", busy, 0);
    check("b_idle_rd", imem_rd, 0);
    check("b_idle_flagq", flag_q, 4'b1010);
    check("b_idle_halted", halted, 0);
    fetch_exp.push_back(8'h01); fetch_exp.push_back(8'h02);
    issue_exp.push_back(W3);
    run = 1'b1;
    wait_halt("b_halt", 60);
    check("b_pc_halted", pc, 2);
    check_drained("b");

    // C: pc wraps 255 -> 0
    waits = 0; spurious = 1'b0; flag_drv = 4'b0000; run = 1'b1;
    for (int k = 0; k < 256; k++) begin
      mem[k] = 19'h08000 | 19'(k);
      fetch_exp.push_back(8'(k));
      issue_exp.push_back(19'h08000 | 19'(k));
    end
    fetch_exp.push_back(8'h00);
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (pc === 8'hFF) break;
    end
    check("c_pc_reach_255", pc, 8'hFF);
    mem[0] = HALT;
    wait_halt("c_halt", 40);
    check("c_pc_wrap", pc, 0);
    check_drained("c");

    // D1: BRZ with zero flag set
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = W1; mem[1] = BRZ; mem[2] = HALT; mem[8'h44] = HALT;
    flag_drv = 4'b0001; run = 1'b1;
    fetch_exp.push_back(8'h00); fetch_exp.push_back(8'h01);
    issue_exp.push_back(W1);
`ifdef INSTR_SEQ_BRANCH_EN
    fetch_exp.push_back(8'h44);
    pc_exp = 8'h44;
`else
    fetch_exp.push_back(8'h02);
    issue_exp.push_back(BRZ);
    pc_exp = 8'h02;
`endif
    do_reset();
    wait_halt("d1_halt", 40);
    check("d1_pc", pc, pc_exp);
    check("d1_flagq", flag_q, 4'b0001);
    check_drained("d1");

    // D2: BRZ with zero flag clear
    flag_drv = 4'b0000;
    fetch_exp.push_back(8'h00); fetch_exp.push_back(8'h01); fetch_exp.push_back(8'h02);
    issue_exp.push_back(W1);
`ifndef INSTR_SEQ_BRANCH_EN
    issue_exp.push_back(BRZ);
`endif
    do_reset();
    wait_halt("d2_halt", 40);
    check("d2_pc", pc, 2);
    check("d2_flagq", flag_q, 4'b0000);
    check_drained("d2");

    // E: reset while a fetch is still waiting on memory
    waits = 10; run = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    check("e_rd_waiting", imem_rd, 1);
    rst = 1'b1;
    @(negedge clk);
    check("e_rd_after_rst", imem_rd, 0);
    check("e_busy_after_rst", busy, 0);
    check("e_pc_after_rst", pc, 0);
    run = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_drained("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
